alu_stage: RTL and testbench



---
 rtl/alu_stage.sv | 188 ++++++++++++++++++
 tb/tb_alu_stage.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/alu_stage.sv
// alu_stage: execute-stage ALU. Single-cycle arithmetic, logic and compare ops,
// plus an iterative shifter that stalls upstream while it steps.

package alu_stage_pkg;

    typedef enum logic [3:0] {
        NO_OP = 4'd0,
        ADD   = 4'd1,
        SUB   = 4'd2,
        XOR   = 4'd3,
        OR    = 4'd4,
        AND   = 4'd5,
        LT    = 4'd6,
        LTU   = 4'd7,
        EQ    = 4'd8,
        NEQ   = 4'd9,
        GE    = 4'd10,
        GEU   = 4'd11,
        SLL   = 4'd12,
        SRL   = 4'd13,
        SRA   = 4'd14
    } op_t;

endpackage

module alu_stage
    import alu_stage_pkg::*;
#(
    parameter int unsigned SHIFT_STEP = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_noop,
    input  op_t         in_op,
    input  logic [31:0] in_src1,
    input  logic [31:0] in_src2,
    input  logic        in_flush,
    output logic        out_stall,
    output logic        out_noop,
    output logic [31:0] out_result,
    output logic        out_cond
);

    localparam int unsigned DW = 32;
    localparam int unsigned RW = 6;
    localparam logic [RW-1:0] STEP = RW'(SHIFT_STEP);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t        state, state_d;
    logic [DW-1:0] sh_val, sh_val_d;
    logic [RW-1:0] rem, rem_d;
    op_t           sh_op, sh_op_d;
    logic          noop_d;
    logic [DW-1:0] result_d;
    logic          cond_d;

    logic [4:0]    shamt;
    logic          is_shift;
    logic [DW-1:0] alu_res;
    logic          alu_cond;
    logic [RW-1:0] step;
    logic [DW-1:0] shifted;

    assign shamt    = in_src2[4:0];
    assign is_shift = (in_op == SLL) || (in_op == SRL) || (in_op == SRA);

    // Single-cycle result and condition for the presented op
    always_comb begin
        alu_res  = '0;
        alu_cond = 1'b0;
        case (in_op)
            ADD: alu_res = in_src1 + in_src2;
            SUB: alu_res = in_src1 - in_src2;
            XOR: alu_res = in_src1 ^ in_src2;
            OR:  alu_res = in_src1 | in_src2;
            AND: alu_res = in_src1 & in_src2;
            LT: begin
                alu_cond = $signed(in_src1) < $signed(in_src2);
                alu_res  = DW'(alu_cond);
            end
            LTU: begin
                alu_cond = in_src1 < in_src2;
                alu_res  = DW'(alu_cond);
            end
            EQ:  alu_cond = in_src1 == in_src2;
            NEQ: alu_cond = in_src1 != in_src2;
            GE:  alu_cond = $signed(in_src1) >= $signed(in_src2);
            GEU: alu_cond = in_src1 >= in_src2;
            SLL, SRL, SRA: alu_res = in_src1;  // only reached with shamt == 0
            default: begin
                alu_res  = '0;
                alu_cond = 1'b0;
            end
        endcase
    end

    // One shifter iteration: move by min(rem, SHIFT_STEP)
    always_comb begin
        step    = (rem < STEP) ? rem : STEP;
        shifted = sh_val;
        case (sh_op)
            SLL:     shifted = sh_val << step;
            SRL:     shifted = sh_val >> step;
            SRA:     shifted = DW'($signed(sh_val) >>> step);
            default: shifted = sh_val;
        endcase
    end

    // Next-state, stall and registered-output decisions
    always_comb begin
        state_d   = state;
        sh_val_d  = sh_val;
        rem_d     = rem;
        sh_op_d   = sh_op;
        noop_d    = out_noop;
        result_d  = out_result;
        cond_d    = out_cond;
        out_stall = 1'b0;

        if (!rst_n) begin
            out_stall = 1'b0;
        end else if (in_flush) begin
            state_d  = IDLE;
            rem_d    = '0;
            noop_d   = 1'b1;
            result_d = '0;
            cond_d   = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_noop || (in_op == NO_OP)) begin
                        noop_d   = 1'b1;
                        result_d = '0;
                        cond_d   = 1'b0;
                    end else if (is_shift && (shamt != 5'd0)) begin
                        out_stall = 1'b1;
                        sh_val_d  = in_src1;
                        rem_d     = RW'(shamt);
                        sh_op_d   = in_op;
                        noop_d    = 1'b1;
                        state_d   = SHIFT;
                    end else begin
                        noop_d   = 1'b0;
                        result_d = alu_res;
                        cond_d   = alu_cond;
                    end
                end
                SHIFT: begin
                    sh_val_d = shifted;
                    rem_d    = rem - step;
                    if (rem > STEP) begin
                        out_stall = 1'b1;
                        noop_d    = 1'b1;
                    end else begin
                        noop_d   = 1'b0;
                        result_d = shifted;
                        cond_d   = 1'b0;
                        state_d  = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            sh_val     <= '0;
            rem        <= '0;
            sh_op      <= NO_OP;
            out_noop   <= 1'b1;
            out_result <= '0;
            out_cond   <= 1'b0;
        end else begin
            state      <= state_d;
            sh_val     <= sh_val_d;
            rem        <= rem_d;
            sh_op      <= sh_op_d;
            out_noop   <= noop_d;
            out_result <= result_d;
            out_cond   <= cond_d;
        end
    end

endmodule

// File: tb/tb_alu_stage.sv
// Scoreboard bench for alu_stage with SHIFT_STEP=1.

module tb_alu_stage;
    import alu_stage_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        in_noop;
    op_t         in_op;
    logic [31:0] in_src1;
    logic [31:0] in_src2;
    logic        in_flush;
    logic        out_stall;
    logic        out_noop;
    logic [31:0] out_result;
    logic        out_cond;

    int checks   = 0;
    int failures = 0;

    logic [32:0] sb[$];

    alu_stage #(.SHIFT_STEP(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_noop    (in_noop),
        .in_op      (in_op),
        .in_src1    (in_src1),
        .in_src2    (in_src2),
        .in_flush   (in_flush),
        .out_stall  (out_stall),
        .out_noop   (out_noop),
        .out_result (out_result),
        .out_cond   (out_cond)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Monitor: every valid output must match the oldest expected entry
    always @(negedge clk) begin
        logic [32:0] exp;
        if (rst_n === 1'b1 && out_noop === 1'b0) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_output actual=%h/%b expected=none", out_result, out_cond);
            end else begin
                exp = sb.pop_front();
                if ({out_result, out_cond} !== exp) begin
                    failures++;
                    $display("FAIL result actual=%h/%b expected=%h/%b",
                             out_result, out_cond, exp[32:1], exp[0]);
                end
            end
        end
    end

    // Present one op, hold it while stalled, count stall cycles; entered and left at posedge+1
    task automatic send(input op_t op, input logic [31:0] a, input logic [31:0] b,
                        input int exp_stalls, input logic [31:0] er, input logic ec);
        int n;
        in_noop = 1'b0;
        in_op   = op;
        in_src1 = a;
        in_src2 = b;
        sb.push_back({er, ec});
        n = 0;
        #1;
        while (out_stall === 1'b1 && n < 100) begin
            n++;
            @(posedge clk); #2;
            check("noop_while_shifting", 32'(out_noop), 32'd1);
        end
        check("stall_cycles", 32'(n), 32'(exp_stalls));
        @(posedge clk); #1;
        in_noop = 1'b1;
        in_op   = NO_OP;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        in_noop  = 1'b1;
        in_op    = NO_OP;
        in_src1  = '0;
        in_src2  = '0;
        in_flush = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_stall", 32'(out_stall), 32'd0);
        check("reset_noop", 32'(out_noop), 32'd1);
        check("reset_result", out_result, 32'd0);
        check("reset_cond", 32'(out_cond), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single-cycle ops
        send(ADD, 32'h7FFF_FFFF, 32'h0000_0001, 0, 32'h8000_0000, 1'b0);
        send(SRA, 32'h8000_0000, 32'h0000_0023, 3, 32'hF000_0000, 1'b0);
        send(SLL, 32'h1234_5678, 32'h0000_0020, 0, 32'h1234_5678, 1'b0);
        send(LTU, 32'h0000_0001, 32'hFFFF_FFFF, 0, 32'h0000_0001, 1'b1);
        send(LT,  32'h0000_0001, 32'hFFFF_FFFF, 0, 32'h0000_0000, 1'b0);
        send(GE,  32'hFFFF_FFFB, 32'hFFFF_FFFB, 0, 32'h0000_0000, 1'b1);
        send(SUB, 32'h0000_0000, 32'h0000_0001, 0, 32'hFFFF_FFFF, 1'b0);
        send(XOR, 32'hF0F0_F0F0, 32'hFF00_FF00, 0, 32'h0FF0_0FF0, 1'b0);
        send(OR,  32'h0000_000F, 32'h0000_00F0, 0, 32'h0000_00FF, 1'b0);
        send(AND, 32'hFF00_FF00, 32'h0FF0_0FF0, 0, 32'h0F00_0F00, 1'b0);
        send(NEQ, 32'h0000_0003, 32'h0000_0004, 0, 32'h0000_0000, 1'b1);
        send(GEU, 32'h0000_0000, 32'h0000_0001, 0, 32'h0000_0000, 1'b0);
        send(EQ,  32'h0000_0007, 32'h0000_0008, 0, 32'h0000_0000, 1'b0);

        // Iterative shifts
        send(SLL, 32'h0000_0001, 32'h0000_0001, 1, 32'h0000_0002, 1'b0);
        send(SRA, 32'h7FFF_FFF0, 32'h0000_0004, 4, 32'h07FF_FFFF, 1'b0);
        send(SRL, 32'h8000_0000, 32'h0000_001F, 31, 32'h0000_0001, 1'b0);

        // Bubbles produce no output
        in_noop = 1'b1; in_op = ADD; in_src1 = 32'd1; in_src2 = 32'd1;
        @(posedge clk); #1;
        check("bubble_noop", 32'(out_noop), 32'd1);
        in_noop = 1'b0; in_op = NO_OP;
        @(posedge clk); #1;
        check("no_op_noop", 32'(out_noop), 32'd1);
        in_noop = 1'b1;

        // Flush during the second SHIFT cycle
        in_noop = 1'b0; in_op = SRL; in_src1 = 32'hFFFF_FFFF; in_src2 = 32'd31;
        @(posedge clk); #1;
        @(posedge clk); #1;
        in_flush = 1'b1;
        #1;
        check("flush_stall", 32'(out_stall), 32'd0);
        @(posedge clk); #1;
        in_flush = 1'b0; in_noop = 1'b1; in_op = NO_OP;
        #1;
        check("flush_noop", 32'(out_noop), 32'd1);
        check("flush_stall_after", 32'(out_stall), 32'd0);
        @(posedge clk); #1;
        send(ADD, 32'd2, 32'd3, 0, 32'd5, 1'b0);

        // Reset in the middle of a long shift
        in_noop = 1'b0; in_op = SLL; in_src1 = 32'd1; in_src2 = 32'd20;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0; in_noop = 1'b1; in_op = NO_OP;
        #1;
        check("rst_mid_stall", 32'(out_stall), 32'd0);
        @(posedge clk); #1;
        check("rst_mid_noop", 32'(out_noop), 32'd1);
        check("rst_mid_result", out_result, 32'd0);
        check("rst_mid_cond", 32'(out_cond), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        send(EQ, 32'd7, 32'd7, 0, 32'd0, 1'b1);

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
